// File: rtl/add_if_pkg.sv
// Shared types and widths for the add_if operand/result bundle.
package add_if_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned DEFAULT_SUM_WIDTH = DEFAULT_WIDTH + 1;

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] a;
      logic [DEFAULT_WIDTH-1:0] b;
   } operands_t;

   typedef logic [DEFAULT_SUM_WIDTH-1:0] sum_t;

   // Full-width unsigned add; the carry lands in the MSB.
   function automatic sum_t add_operands(input operands_t ops);
      return sum_t'(ops.a) + sum_t'(ops.b);
   endfunction

endpackage

// File: rtl/add_if_skid.sv
// Generic 2-entry valid/ready register slice: output register plus one skid entry.
module add_if_skid #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         in_ready_q, in_ready_d;

   logic accept_c;
   logic fire_c;

   assign accept_c = in_valid_i && in_ready_q;
   assign fire_c   = out_valid_q && out_ready_i;

   // Next-state: data is only ever loaded on an accepted transfer.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      if (skid_valid_q) begin
         if (fire_c) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         if (!out_valid_q || fire_c) begin
            out_data_d  = in_data_i;
            out_valid_d = 1'b1;
         end else begin
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
         end
      end else if (fire_c) begin
         out_valid_d = 1'b0;
      end

      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/add_if_core.sv
// Registered unsigned adder with valid/ready handshakes and one cycle of latency.
module add_if_core
   import add_if_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);

   localparam int unsigned SUM_W = WIDTH + 1;

   logic [SUM_W-1:0] sum_c;

   // Zero-extend both operands so the carry is kept.
   assign sum_c = SUM_W'(a) + SUM_W'(b);

   add_if_skid #(
      .W (SUM_W)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (sum_c),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (sum)
   );

endmodule

// File: tb/tb_add_if_core.sv
// Directed self-checking bench for add_if_core.
module tb_add_if_core;
   import add_if_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] sum;

   int checks;
   int failures;

   add_if_core #(
      .WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single pair with out_ready high; result is checked one edge later, then drained.
   task automatic send_one(input logic [3:0] av, input logic [3:0] bv, input logic [4:0] exp,
                           input string tag);
      a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_sum"}, 32'(sum), 32'(exp));
      step();
      check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   logic [3:0] sa [8];
   logic [3:0] sb [8];
   logic [4:0] se [8];

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;

      sa = '{4'd1, 4'd4, 4'd15, 4'd8, 4'd0, 4'd10, 4'd6, 4'd12};
      sb = '{4'd2, 4'd5, 4'd14, 4'd8, 4'd7, 4'd3, 4'd11, 4'd12};
      se = '{5'd3, 5'd9, 5'd29, 5'd16, 5'd7, 5'd13, 5'd17, 5'd24};

      repeat (3) step();
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_sum", 32'(sum), 32'd0);
      rst_n = 1'b1;
      step();
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Basic transaction and boundary values
      send_one(4'd1, 4'd3, 5'd4, "t1_1p3");
      send_one(4'd15, 4'd15, 5'd30, "t2_max");
      send_one(4'd0, 4'd0, 5'd0, "t2_zero");
      send_one(4'd15, 4'd1, 5'd16, "t2_carry");

      // Back-to-back stream at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = sa[i]; b = sb[i]; in_valid = 1'b1;
         step();
         check_eq($sformatf("t3_valid%0d", i), 32'(out_valid), 32'd1);
         check_eq($sformatf("t3_sum%0d", i), 32'(sum), 32'(se[i]));
         check_eq($sformatf("t3_ready%0d", i), 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      step();
      check_eq("t3_end_valid", 32'(out_valid), 32'd0);

      // Backpressure fills output and skid, then drains in order
      out_ready = 1'b0;
      a = 4'd2; b = 4'd2; in_valid = 1'b1;
      step();
      check_eq("t4_first_valid", 32'(out_valid), 32'd1);
      check_eq("t4_first_sum", 32'(sum), 32'd4);
      check_eq("t4_first_ready", 32'(in_ready), 32'd1);
      a = 4'd3; b = 4'd3;
      step();
      check_eq("t4_skid_ready", 32'(in_ready), 32'd0);
      check_eq("t4_skid_sum", 32'(sum), 32'd4);
      a = 4'd4; b = 4'd4;
      step();
      check_eq("t4_hold_ready", 32'(in_ready), 32'd0);
      check_eq("t4_hold_sum", 32'(sum), 32'd4);
      check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step();
      check_eq("t4_drain1_sum", 32'(sum), 32'd6);
      check_eq("t4_drain1_valid", 32'(out_valid), 32'd1);
      check_eq("t4_drain1_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check_eq("t4_third_sum", 32'(sum), 32'd8);
      check_eq("t4_third_valid", 32'(out_valid), 32'd1);
      step();
      check_eq("t4_empty_valid", 32'(out_valid), 32'd0);

      // Reset with a result pending discards it
      out_ready = 1'b0;
      a = 4'd5; b = 4'd6; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq("t5_pending_sum", 32'(sum), 32'd11);
      rst_n = 1'b0;
      step();
      check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
      check_eq("t5_rst_sum", 32'(sum), 32'd0);
      check_eq("t5_rst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq($sformatf("t5_no_emit%0d", i), 32'(out_valid), 32'd0);
      end
      check_eq("t5_ready_back", 32'(in_ready), 32'd1);

      // Idle operands, including unknowns, never produce a result
      for (int i = 0; i < 10; i++) begin
         if (i < 5) begin
            a = 'x; b = 'x;
         end else begin
            a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
         end
         step();
         check_eq($sformatf("t6_valid%0d", i), 32'(out_valid), 32'd0);
         check_eq($sformatf("t6_sum%0d", i), 32'(sum), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
